// File: rtl/psg_write_sequencer.sv
// Purpose: arbitrates two 13-bit PSG command sources and plays each command
//          onto the SN76489 write port as one or two latch/data bytes.
// Latency: accept on tick t0, byte asserted on t1 (if ti_ready_i), released after
//          HOLD_TICKS ticks, one GAP tick per byte; DONE pulses in the final GAP.
// Backpressure: a requester is held until its one-cycle ready strobe; ti_ready_i low
//          in WAIT stalls indefinitely and is ignored in ASSERT/GAP.
//
// Ports: clk_i/rst_i (async active-high), tick_i (PSG clock-enable pulse),
//        reqN_valid_i/reqN_cmd_i/reqN_ready_o (cmd = {ch[1:0], type, value[9:0]}),
//        ti_ready_i/ti_nwe_o/ti_nce_o/ti_d_o (PSG write port), busy_o, done_o.
module psg_write_sequencer #(
  parameter int unsigned HOLD_TICKS = 2  // legal range 1..15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        req0_valid_i,
  input  logic [12:0] req0_cmd_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [12:0] req1_cmd_i,
  output logic        req1_ready_o,
  input  logic        ti_ready_i,
  output logic        ti_nwe_o,
  output logic        ti_nce_o,
  output logic [7:0]  ti_d_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [3:0] HOLD = 4'(HOLD_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ASSERT, S_GAP} state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic [12:0] cmd_q, cmd_d;
  logic        idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        nwe_q, nwe_d;
  logic [7:0]  d_q, d_d;

  logic        grant0, grant1;
  logic        two_byte;
  logic [7:0]  byte0, byte1;
  logic        strobe_ok;

  // Byte encoding of the latched command. Channel 3 with type 0 is the
  // noise register, which only has a 3-bit value and no second byte.
  always_comb begin
    two_byte = !cmd_q[10] && (cmd_q[12:11] != 2'd3);
    byte1    = {2'b00, cmd_q[9:4]};
    if (cmd_q[10]) begin
      byte0 = {1'b1, cmd_q[12:11], 1'b1, cmd_q[3:0]};
    end else if (cmd_q[12:11] == 2'd3) begin
      byte0 = {5'b11100, cmd_q[2:0]};
    end else begin
      byte0 = {1'b1, cmd_q[12:11], 1'b0, cmd_q[3:0]};
    end
  end

  // Round robin: a lone requester always wins; on contention prio_q decides.
  assign grant1 = req1_valid_i && (!req0_valid_i || prio_q);
  assign grant0 = req0_valid_i && !grant1;

  // Strobes are combinational and only exist on a tick cycle outside reset.
  assign strobe_ok = tick_i && !rst_i;

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    cmd_d        = cmd_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    nwe_d        = nwe_q;
    d_d          = d_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req0_valid_i || req1_valid_i) begin
          req0_ready_o = strobe_ok && grant0;
          req1_ready_o = strobe_ok && grant1;
          cmd_d        = grant1 ? req1_cmd_i : req0_cmd_i;
          prio_d       = !grant1;
          idx_d        = 1'b0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ti_ready_i) begin
          d_d     = idx_q ? byte1 : byte0;
          nwe_d   = 1'b0;
          cnt_d   = HOLD;
          state_d = S_ASSERT;
        end
      end
      S_ASSERT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          nwe_d   = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (two_byte && !idx_q) begin
          idx_d   = 1'b1;
          state_d = S_WAIT;
        end else begin
          done_o  = strobe_ok;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every register advances only on tick cycles, so the PSG pins are stable
  // for the whole PSG clock period between updates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      cmd_q   <= '0;
      idx_q   <= 1'b0;
      cnt_q   <= '0;
      nwe_q   <= 1'b1;
      d_q     <= '0;
    end else if (tick_i) begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      nwe_q   <= nwe_d;
      d_q     <= d_d;
    end
  end

  // nWE and nCE are strobed together from one register.
  assign ti_nwe_o = nwe_q;
  assign ti_nce_o = nwe_q;
  assign ti_d_o   = d_q;
  assign busy_o   = (state_q != S_IDLE);

endmodule
